// File: rtl/uart_core.sv
// Full-duplex UART: free-running transmitter and mid-bit-sampling receiver
// with configurable data width, parity and stop bits.
module uart_core #(
    parameter int CLK_PER_BIT = 104,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD       = (PARITY == 1);

    // S_WAIT is used only by the receiver, to hold off after a frame error.
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_t;

    state_t                tx_state;
    logic [CW-1:0]         tx_baud;
    logic [3:0]            tx_bit;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (tx_start) begin
                tx_shift <= tx_data;
                tx_par   <= (^tx_data) ^ ODD;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_baud  <= '0;
                tx_bit   <= '0;
                tx_state <= S_START;
            end
        end else if (tx_baud != BAUD_LAST) begin
            tx_baud <= tx_baud + 1'b1;
        end else begin
            tx_baud <= '0;
            case (tx_state)
                S_START: begin
                    tx       <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_state <= S_DATA;
                end
                S_DATA: begin
                    if (tx_bit == DATA_LAST) begin
                        tx_bit <= '0;
                        if (HAS_PAR) begin
                            tx       <= tx_par;
                            tx_state <= S_PARITY;
                        end else begin
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
                        end
                    end else begin
                        tx_bit   <= tx_bit + 1'b1;
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                S_PARITY: begin
                    tx       <= 1'b1;
                    tx_state <= S_STOP;
                end
                S_STOP: begin
                    if (tx_bit == STOP_LAST) begin
                        tx_bit   <= '0;
                        tx       <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

    logic                  rx_s1, rx_s2, rx_prev;
    state_t                rx_state;
    logic [CW-1:0]         rx_baud;
    logic [3:0]            rx_bit;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_par_bit;

    // Synchronizer flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= S_IDLE;
            rx_baud       <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_s1         <= rx;
            rx_s2         <= rx_s1;
            rx_prev       <= rx_s2;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_baud  <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_baud == BAUD_HALF) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    if (rx_baud != BAUD_LAST) begin
                        rx_baud <= rx_baud + 1'b1;
                    end else begin
                        rx_baud <= '0;
                        if (rx_state == S_DATA) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == DATA_LAST) begin
                                rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                            end else begin
                                rx_bit <= rx_bit + 1'b1;
                            end
                        end else if (rx_state == S_PARITY) begin
                            rx_par_bit <= rx_s2;
                            rx_state   <= S_STOP;
                        end else if (rx_s2) begin
                            rx_data       <= rx_shift;
                            rx_valid      <= 1'b1;
                            rx_parity_err <= HAS_PAR && ((^rx_shift) ^ ODD ^ rx_par_bit);
                            rx_state      <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (rx_s2) rx_state <= S_IDLE;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART for the ICEstick designs: configurable data width, parity and stop bits, with a free-running transmitter and a mid-bit-sampling receiver. It replaces the fixed 8N1, transmit-only UART and sits between the USB3300 parser and the FTDI serial pins. The host-side logic sees a simple start/busy handshake on transmit and a one-cycle valid strobe on receive.

## Interface
- CLK_PER_BIT, default 104: clk cycles per bit (12 MHz / 115200); legal ≥ 4.
- DATA_BITS, default 8: payload bits per frame; legal 5..9.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: 1 or 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  payload to send; sampled when a start is accepted.
- tx_start  in  1  request; accepted only in a cycle where tx_busy = 0.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  transmitter occupied.
- rx  in  1  serial input, asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload, held until the next valid frame.
- rx_valid  out  1  one-cycle strobe: new rx_data.
- rx_frame_err  out  1  one-cycle strobe: stop bit sampled low.
- rx_parity_err  out  1  one-cycle strobe: parity mismatch.

## Operation
- Reset values: tx = 1, tx_busy = 0, rx_data = 0, and all strobes 0. Both FSMs go to IDLE and all counters clear. Assertion mid-frame aborts the frame immediately: tx returns high and the partial rx frame is discarded.
- The frame is LSB-first: start (0), DATA_BITS payload bits, an optional parity bit, then STOP_BITS stop bits (1).
- Parity is the XOR of the payload, inverted for odd parity.
- Tx FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - A bit counter counts payload and stop bits.
  - A baud counter runs 0..CLK_PER_BIT-1 and wraps to 0 at every bit boundary.
  - tx_start while busy is ignored, not queued.
  - The tx_data value is latched on acceptance. Later changes to tx_data do not affect the frame in flight.
- Rx input path: rx passes through a 2-flop synchronizer. The FSM uses only the synchronized value.
- Rx FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - IDLE → START on a synchronized high→low transition.
  - In START, the line is resampled after (CLK_PER_BIT-1)/2 cycles. If it reads 1, the event is a glitch: return to IDLE with no strobe.
  - Each later bit is sampled CLK_PER_BIT cycles after the previous sample, i.e. at mid-bit.
  - Only the first stop bit is checked. The FSM returns to IDLE right after that sample, so a new start edge can be caught during a second stop bit.
- End-of-frame outcomes at the stop sample:
  - Stop bit = 1: rx_valid pulses, and rx_parity_err pulses in the same cycle if parity mismatched. rx_data updates in both cases.
  - Stop bit = 0: rx_frame_err pulses. rx_valid and rx_parity_err stay 0, and rx_data is unchanged.
  - After a frame error, the FSM waits for rx = 1 before it re-arms IDLE edge detection. A break condition therefore produces one error, not repeated errors.
- The transmitter and receiver are fully independent; simultaneous activity is legal.

## Timing
- Tx start: if tx_start = 1 and tx_busy = 0 at edge N, then tx = 0 and tx_busy = 1 from edge N+1.
- Each tx bit lasts exactly CLK_PER_BIT cycles.
- tx_busy falls at the edge where the last stop bit completes, i.e. (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles after edge N+1.
- A tx_start held high then restarts at the next edge. Back-to-back frames therefore have a 1-cycle idle-high gap.
- Rx detection latency: 2 cycles of synchronizer plus 1 cycle of edge detect after the pin falls.
- rx_valid / rx_frame_err / rx_parity_err assert 1 cycle after the stop-bit sample and last exactly 1 cycle.
- Sampling tolerance: ±(CLK_PER_BIT/2 − 3) cycles of accumulated drift per frame.

## Test plan
- Reset with defaults overridden to CLK_PER_BIT = 16, 8N1. Pulse tx_start with tx_data = 0xA5 → tx = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1. tx_busy is high for exactly 160 cycles.
- Set tx_start while busy with tx_data = 0x00 → ignored; the waveform is unchanged. Then hold tx_start high over two frames → exactly a 1-cycle high gap between them.
- Loop tx to rx with DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, and send 0x5A → one rx_valid with rx_data = 0x5A and no error strobes.
- Drive an 8O1 frame of 0x3C with the parity bit flipped → rx_valid and rx_parity_err in the same cycle, rx_data = 0x3C.
- Drive a frame with stop = 0, then hold rx low for 50 bit times → exactly one rx_frame_err pulse, no rx_valid, rx_data unchanged. Re-arm only after rx returns high.
- Drive a 5-cycle low glitch on rx → no strobe. Assert rst_n low mid-tx-frame → tx = 1 and tx_busy = 0 asynchronously, then a clean frame after release.
